// File: rtl/fixed_point_parser_if.sv
// Character-in / number-out handshake bundle for the ASCII fixed-point parser.
// The master side drives characters and takes numbers; the slave side is the parser.
interface fixed_point_parser_if #(
  parameter int LEN = 32
);
  logic [7:0]     ch_data;
  logic           ch_valid;
  logic           ch_ready;
  logic [LEN-1:0] num_out;
  logic           num_valid;
  logic           num_ready;
  logic [7:0]     term_char;
  logic           ovf;
  logic           err;

  modport master (
    output ch_data, ch_valid, num_ready,
    input  ch_ready, num_out, num_valid, term_char, ovf, err
  );

  modport slave (
    input  ch_data, ch_valid, num_ready,
    output ch_ready, num_out, num_valid, term_char, ovf, err
  );
endinterface

// File: rtl/fixed_point_parser.sv
// ASCII decimal field -> sign-magnitude fixed-point word {sign, int_part, frac_part}.
// frac_part is the decimal fraction scaled by 10^FRAC_DIGITS. Short fractions are
// left-aligned by a PAD phase that multiplies by ten once per missing digit.
module fixed_point_parser #(
  parameter int INT_W       = 17,
  parameter int FRAC_W      = 14,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  fixed_point_parser_if.slave  bus
);

  localparam int N_W        = $clog2(FRAC_DIGITS + 1);
  localparam int MAX_FRAC_I = 10**FRAC_DIGITS - 1;
  localparam logic [N_W-1:0]    FD       = N_W'(FRAC_DIGITS);
  localparam logic [N_W-1:0]    FD_M1    = N_W'(FRAC_DIGITS - 1);
  localparam logic [INT_W-1:0]  INT_MAX  = {INT_W{1'b1}};
  localparam logic [FRAC_W-1:0] MAX_FRAC = FRAC_W'(MAX_FRAC_I);

  typedef enum logic [2:0] {S_IDLE, S_INT, S_FRAC, S_PAD, S_OUT} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [N_W-1:0]     n_q, n_d;
  logic               ovf_q, ovf_d;
  logic               dig_q, dig_d;
  logic [7:0]         term_q, term_d;

  logic               ch_ready_w;
  logic               xfer;
  logic               is_dig;
  logic [3:0]         dval;
  logic [INT_W:0]     int_res;
  logic               out_st;
  logic               mag_zero;

  // x*10 + d via shift-add, saturating to the integer field; returns {ovf, value}
  function automatic logic [INT_W:0] int_mac(input logic [INT_W-1:0] x,
                                             input logic [3:0]       d);
    logic [INT_W+3:0] acc;
    acc = ({4'd0, x} << 3) + ({4'd0, x} << 1) + {{INT_W{1'b0}}, d};
    if (acc > {4'd0, INT_MAX})
      return {1'b1, INT_MAX};
    return {1'b0, acc[INT_W-1:0]};
  endfunction

  // x*10 + d for the fraction; the clamp is defensive, digit counting keeps it in range
  function automatic logic [FRAC_W-1:0] frac_mac(input logic [FRAC_W-1:0] x,
                                                 input logic [3:0]        d);
    logic [FRAC_W+3:0] acc;
    acc = ({4'd0, x} << 3) + ({4'd0, x} << 1) + {{FRAC_W{1'b0}}, d};
    if (acc > {4'd0, MAX_FRAC})
      return MAX_FRAC;
    return acc[FRAC_W-1:0];
  endfunction

  assign ch_ready_w = (state_q == S_IDLE) || (state_q == S_INT) || (state_q == S_FRAC);
  assign xfer       = bus.ch_valid & ch_ready_w;
  assign is_dig     = (bus.ch_data >= 8'h30) && (bus.ch_data <= 8'h39);
  assign dval       = bus.ch_data[3:0];

  // Next-state and accumulator update for the character FSM
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    int_d   = int_q;
    frac_d  = frac_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    term_d  = term_q;
    int_res = int_mac(int_q, dval);

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (bus.ch_data == 8'h20 || bus.ch_data == 8'h09) begin
            state_d = S_IDLE;
          end else if (bus.ch_data == 8'h2D) begin
            sign_d  = 1'b1;
            state_d = S_INT;
          end else if (bus.ch_data == 8'h2B) begin
            state_d = S_INT;
          end else if (is_dig) begin
            int_d   = {{(INT_W-4){1'b0}}, dval};
            dig_d   = 1'b1;
            state_d = S_INT;
          end else if (bus.ch_data == 8'h2E) begin
            state_d = S_FRAC;
          end else begin
            term_d  = bus.ch_data;
            state_d = (n_q < FD) ? S_PAD : S_OUT;
          end
        end
      end
      S_INT: begin
        if (xfer) begin
          if (is_dig) begin
            dig_d = 1'b1;
            // once saturated, later integer digits are swallowed
            if (!ovf_q) begin
              ovf_d = int_res[INT_W];
              int_d = int_res[INT_W-1:0];
            end
          end else if (bus.ch_data == 8'h2E) begin
            state_d = S_FRAC;
          end else begin
            term_d  = bus.ch_data;
            state_d = (n_q < FD) ? S_PAD : S_OUT;
          end
        end
      end
      S_FRAC: begin
        if (xfer) begin
          if (is_dig) begin
            dig_d = 1'b1;
            // digits beyond FRAC_DIGITS are truncated, not rounded
            if (n_q < FD) begin
              frac_d = frac_mac(frac_q, dval);
              n_d    = n_q + 1'b1;
            end
          end else begin
            term_d  = bus.ch_data;
            state_d = (n_q < FD) ? S_PAD : S_OUT;
          end
        end
      end
      S_PAD: begin
        frac_d = frac_mac(frac_q, 4'd0);
        n_d    = n_q + 1'b1;
        if (n_q == FD_M1)
          state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.num_ready) begin
          state_d = S_IDLE;
          sign_d  = 1'b0;
          int_d   = '0;
          frac_d  = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          dig_d   = 1'b0;
          term_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and accumulator registers; clear aborts synchronously and beats any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= 1'b0;
      term_q  <= '0;
    end else if (clear) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= 1'b0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      term_q  <= term_d;
    end
  end

  // Results are only presented in OUT; a zero magnitude never carries a minus sign
  assign out_st        = (state_q == S_OUT);
  assign mag_zero      = (int_q == '0) && (frac_q == '0);
  assign bus.ch_ready  = ch_ready_w;
  assign bus.num_valid = out_st;
  assign bus.num_out   = out_st ? {sign_q & ~mag_zero, int_q, frac_q} : '0;
  assign bus.term_char = out_st ? term_q : 8'd0;
  assign bus.ovf       = out_st & ovf_q;
  assign bus.err       = out_st & ~dig_q;

endmodule
